// File: rtl/sva_svu_pkg.sv
// Shared types and helpers for the sampled-value unit: past_sel width and saturating counters.
// Latency: n/a (package). Backpressure: n/a.
package sva_svu_pkg;

    typedef logic [31:0] cnt_t;

    function automatic int svu_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Counters narrower than cnt_t saturate at 2^w-1 rather than wrapping.
    function automatic cnt_t sat_inc(input cnt_t v, input int w);
        cnt_t max_v;
        max_v = (w >= 32) ? '1 : ((cnt_t'(1) << w) - cnt_t'(1));
        return (v >= max_v) ? max_v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/svu_history.sv
// Gated sample history: hist shift register, previous flag, fill count and $past distance mux.
// Latency: read ports are combinational views of the state as of the last sample edge.
// Backpressure: none; sample_en low simply holds all state.
module svu_history
    import sva_svu_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int               SEL_W = svu_sel_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             flag_in,
    input  logic [SEL_W-1:0] past_sel,
    output logic [WIDTH-1:0] last_data,
    output logic             last_flag,
    output logic [WIDTH-1:0] sel_data,
    output logic             sel_valid
);

    logic [WIDTH-1:0] hist [DEPTH];
    logic [SEL_W-1:0] fill;
    logic [SEL_W-1:0] n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= INIT;
            last_flag <= 1'b0;
            fill      <= '0;
        end else if (sample_en) begin
            hist[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
            last_flag <= flag_in;
            if (fill != SEL_W'(DEPTH)) fill <= fill + SEL_W'(1);
        end
    end

    // Out-of-range distances are clamped into 1..DEPTH.
    always_comb begin
        n = past_sel;
        if (past_sel == '0)
            n = SEL_W'(1);
        else if (past_sel > SEL_W'(DEPTH))
            n = SEL_W'(DEPTH);
        sel_data = INIT;
        for (int i = 0; i < DEPTH; i++)
            if (n == SEL_W'(i + 1)) sel_data = hist[i];
    end

    assign sel_valid = (fill >= n);
    assign last_data = hist[0];

endmodule

// File: rtl/sva_sampled_value_unit.sv
// Registered $past/$stable/$changed/$rose/$fell with saturating rise/fall counters; SVU_RUN_LEN_EN adds run_len.
// Latency: 1 clock from a sample edge to its results; results hold between samples.
// Backpressure: none; a sample may be taken every clock.
module sva_sampled_value_unit
    import sva_svu_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 4,
    parameter int               CNT_W = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       flag_in,
    input  logic [$clog2(DEPTH+1)-1:0] past_sel,
    input  logic                       clr_cnt,
    output logic [WIDTH-1:0]           past_data,
    output logic                       past_valid,
    output logic                       stable,
    output logic                       changed,
    output logic                       rose,
    output logic                       fell,
    output logic [CNT_W-1:0]           rise_cnt,
    output logic [CNT_W-1:0]           fall_cnt,
    output logic [CNT_W-1:0]           run_len
);

    localparam int SEL_W = svu_sel_w(DEPTH);

    logic [WIDTH-1:0] last_data;
    logic [WIDTH-1:0] sel_data;
    logic             last_flag;
    logic             sel_valid;

    svu_history #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .INIT  (INIT),
        .SEL_W (SEL_W)
    ) u_history (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .data_in   (data_in),
        .flag_in   (flag_in),
        .past_sel  (past_sel),
        .last_data (last_data),
        .last_flag (last_flag),
        .sel_data  (sel_data),
        .sel_valid (sel_valid)
    );

    logic smp_stable;
    logic smp_rose;
    logic smp_fell;
    cnt_t rise_inc;
    cnt_t fall_inc;

    assign smp_stable = (data_in == last_data);
    assign smp_rose   = flag_in & ~last_flag;
    assign smp_fell   = ~flag_in & last_flag;
    assign rise_inc   = sat_inc(cnt_t'(rise_cnt), CNT_W);
    assign fall_inc   = sat_inc(cnt_t'(fall_cnt), CNT_W);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            past_data  <= '0;
            past_valid <= 1'b0;
            stable     <= 1'b0;
            changed    <= 1'b0;
            rose       <= 1'b0;
            fell       <= 1'b0;
            rise_cnt   <= '0;
            fall_cnt   <= '0;
        end else begin
            if (sample_en) begin
                past_data  <= sel_data;
                past_valid <= sel_valid;
                stable     <= smp_stable;
                changed    <= ~smp_stable;
                rose       <= smp_rose;
                fell       <= smp_fell;
                if (smp_rose) rise_cnt <= rise_inc[CNT_W-1:0];
                if (smp_fell) fall_cnt <= fall_inc[CNT_W-1:0];
            end
            // Clear overrides any same-edge event.
            if (clr_cnt) begin
                rise_cnt <= '0;
                fall_cnt <= '0;
            end
        end
    end

`ifdef SVU_RUN_LEN_EN
    cnt_t run_inc;
    logic unused_inc_bits;

    assign run_inc         = sat_inc(cnt_t'(run_len), CNT_W);
    assign unused_inc_bits = ^{rise_inc, fall_inc, run_inc};

    always_ff @(posedge clk) begin
        if (!rst_n)
            run_len <= '0;
        else if (clr_cnt)
            run_len <= '0;
        else if (sample_en)
            run_len <= smp_stable ? run_inc[CNT_W-1:0] : '0;
    end
`else
    logic unused_inc_bits;

    assign unused_inc_bits = ^{rise_inc, fall_inc};
    assign run_len         = '0;
`endif

endmodule

// File: tb/tb_sva_sampled_value_unit.sv
// Bench for sva_sampled_value_unit: directed vector table, corner sequences, then random traffic vs a queue model.
// Two instances share stimulus: default CNT_W=8 and CNT_W=2 for saturation.
module tb_sva_sampled_value_unit;

    localparam logic [7:0] INIT_V = 8'h00;
    localparam int         DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_en = 1'b0;
    logic [7:0] data_in = '0;
    logic       flag_in = 1'b0;
    logic [2:0] past_sel = 3'd1;
    logic       clr_cnt = 1'b0;

    logic [7:0] a_past_data, b_past_data;
    logic       a_past_valid, a_stable, a_changed, a_rose, a_fell;
    logic       b_past_valid, b_stable, b_changed, b_rose, b_fell;
    logic [7:0] a_rise_cnt, a_fall_cnt, a_run_len;
    logic [1:0] b_rise_cnt, b_fall_cnt, b_run_len;

    always #5 clk = ~clk;

    sva_sampled_value_unit #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(8), .INIT(INIT_V)) dut_a (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .data_in(data_in), .flag_in(flag_in),
        .past_sel(past_sel), .clr_cnt(clr_cnt), .past_data(a_past_data), .past_valid(a_past_valid),
        .stable(a_stable), .changed(a_changed), .rose(a_rose), .fell(a_fell),
        .rise_cnt(a_rise_cnt), .fall_cnt(a_fall_cnt), .run_len(a_run_len));

    sva_sampled_value_unit #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(2), .INIT(INIT_V)) dut_b (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .data_in(data_in), .flag_in(flag_in),
        .past_sel(past_sel), .clr_cnt(clr_cnt), .past_data(b_past_data), .past_valid(b_past_valid),
        .stable(b_stable), .changed(b_changed), .rose(b_rose), .fell(b_fell),
        .rise_cnt(b_rise_cnt), .fall_cnt(b_fall_cnt), .run_len(b_run_len));

    int checks = 0;
    int errors = 0;

    // Reference model: list of the most recent samples plus event tallies.
    logic [7:0] hq[$];
    logic       m_flag;
    logic [7:0] e_past;
    logic       e_pv, e_st, e_ch, e_ro, e_fe;
    int         rc, fc, rl;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int exp_run(input int v, input int mx);
`ifdef SVU_RUN_LEN_EN
        return sat(v, mx);
`else
        return 0 * v * mx;
`endif
    endfunction

    task automatic model_step();
        int         n;
        logic [7:0] prev;
        if (!rst_n) begin
            hq.delete();
            m_flag = 1'b0;
            e_past = '0; e_pv = 0; e_st = 0; e_ch = 0; e_ro = 0; e_fe = 0;
            rc = 0; fc = 0; rl = 0;
        end else begin
            if (sample_en) begin
                n = (past_sel == 0) ? 1 : ((int'(past_sel) > DEPTH) ? DEPTH : int'(past_sel));
                prev = (hq.size() > 0) ? hq[$] : INIT_V;
                e_pv = (hq.size() >= n);
                e_past = e_pv ? hq[hq.size() - n] : INIT_V;
                e_st = (data_in == prev);
                e_ch = !e_st;
                e_ro = flag_in && !m_flag;
                e_fe = !flag_in && m_flag;
                if (e_ro) rc++;
                if (e_fe) fc++;
                rl = e_st ? rl + 1 : 0;
                hq.push_back(data_in);
                if (hq.size() > DEPTH) void'(hq.pop_front());
                m_flag = flag_in;
            end
            if (clr_cnt) begin
                rc = 0; fc = 0; rl = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a_past_data", 32'(a_past_data), 32'(e_past));
        chk("a_past_valid", 32'(a_past_valid), 32'(e_pv));
        chk("a_stable", 32'(a_stable), 32'(e_st));
        chk("a_changed", 32'(a_changed), 32'(e_ch));
        chk("a_rose", 32'(a_rose), 32'(e_ro));
        chk("a_fell", 32'(a_fell), 32'(e_fe));
        chk("a_rise_cnt", 32'(a_rise_cnt), 32'(sat(rc, 255)));
        chk("a_fall_cnt", 32'(a_fall_cnt), 32'(sat(fc, 255)));
        chk("a_run_len", 32'(a_run_len), 32'(exp_run(rl, 255)));
        chk("b_past_data", 32'(b_past_data), 32'(e_past));
        chk("b_past_valid", 32'(b_past_valid), 32'(e_pv));
        chk("b_stable", 32'(b_stable), 32'(e_st));
        chk("b_rose", 32'(b_rose), 32'(e_ro));
        chk("b_fell", 32'(b_fell), 32'(e_fe));
        chk("b_rise_cnt", 32'(b_rise_cnt), 32'(sat(rc, 3)));
        chk("b_fall_cnt", 32'(b_fall_cnt), 32'(sat(fc, 3)));
        chk("b_run_len", 32'(b_run_len), 32'(exp_run(rl, 3)));
    endtask

    // Called at a negedge: drive, let one posedge happen, check at the next negedge.
    task automatic cyc(input logic r, input logic en, input logic [7:0] d, input logic f,
                       input logic [2:0] s, input logic c);
        rst_n = r; sample_en = en; data_in = d; flag_in = f; past_sel = s; clr_cnt = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic smp(input logic [7:0] d, input logic f);
        cyc(1'b1, 1'b1, d, f, 3'd1, 1'b0);
    endtask

    typedef struct {
        logic       r, en;
        logic [7:0] d;
        logic       f;
        logic [2:0] s;
        logic       c;
        logic       st, ch, ro, fe;
        logic [7:0] pd;
        logic       pv;
        int         rcnt, fcnt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        //        r  en d      f  s  c   st ch ro fe pd     pv rc fc
        tbl[0]  = '{1, 1, 8'h00, 0, 1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0};
        tbl[1]  = '{1, 1, 8'h00, 1, 1, 0, 1, 0, 1, 0, 8'h00, 1, 1, 0};
        tbl[2]  = '{1, 1, 8'h42, 1, 1, 0, 0, 1, 0, 0, 8'h00, 1, 1, 0};
        tbl[3]  = '{1, 1, 8'h42, 0, 1, 0, 1, 0, 0, 1, 8'h42, 1, 1, 1};
        tbl[4]  = '{0, 1, 8'h77, 1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0};
        tbl[5]  = '{1, 1, 8'h42, 0, 1, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0};
        tbl[6]  = '{1, 1, 8'h55, 0, 3, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0};
        tbl[7]  = '{1, 1, 8'hAA, 0, 1, 0, 0, 1, 0, 0, 8'h55, 1, 0, 0};
        tbl[8]  = '{1, 0, 8'h13, 1, 2, 0, 0, 1, 0, 0, 8'h55, 1, 0, 0};
        tbl[9]  = '{1, 0, 8'h99, 0, 2, 0, 0, 1, 0, 0, 8'h55, 1, 0, 0};
        tbl[10] = '{1, 0, 8'h31, 1, 0, 0, 0, 1, 0, 0, 8'h55, 1, 0, 0};
        tbl[11] = '{1, 1, 8'hAA, 0, 3, 0, 1, 0, 0, 0, 8'h42, 1, 0, 0};
        tbl[12] = '{1, 1, 8'h0F, 0, 0, 0, 0, 1, 0, 0, 8'hAA, 1, 0, 0};
        tbl[13] = '{1, 1, 8'h0F, 0, 7, 0, 1, 0, 0, 0, 8'h55, 1, 0, 0};

        @(negedge clk);
        cyc(1'b0, 1'b1, 8'h5A, 1'b1, 3'd1, 1'b0);
        chk("reset_stable", 32'(a_stable), 32'd0);
        chk("reset_past_valid", 32'(a_past_valid), 32'd0);

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].en, tbl[i].d, tbl[i].f, tbl[i].s, tbl[i].c);
            chk($sformatf("tbl%0d_stable", i), 32'(a_stable), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_changed", i), 32'(a_changed), 32'(tbl[i].ch));
            chk($sformatf("tbl%0d_rose", i), 32'(a_rose), 32'(tbl[i].ro));
            chk($sformatf("tbl%0d_fell", i), 32'(a_fell), 32'(tbl[i].fe));
            chk($sformatf("tbl%0d_past_data", i), 32'(a_past_data), 32'(tbl[i].pd));
            chk($sformatf("tbl%0d_past_valid", i), 32'(a_past_valid), 32'(tbl[i].pv));
            chk($sformatf("tbl%0d_rise_cnt", i), 32'(a_rise_cnt), 32'(tbl[i].rcnt));
            chk($sformatf("tbl%0d_fall_cnt", i), 32'(a_fall_cnt), 32'(tbl[i].fcnt));
        end

        // Saturation of the 2-bit counters, then clear racing a rise.
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            smp(8'h00, 1'b0);
            smp(8'h00, 1'b1);
        end
        chk("sat_b_rise_cnt", 32'(b_rise_cnt), 32'd3);
        chk("sat_a_rise_cnt", 32'(a_rise_cnt), 32'd5);
        chk("sat_b_fall_cnt", 32'(b_fall_cnt), 32'd3);
        smp(8'h00, 1'b0);
        cyc(1'b1, 1'b1, 8'h00, 1'b1, 3'd1, 1'b1);
        chk("clr_rise_a", 32'(a_rise_cnt), 32'd0);
        chk("clr_rise_b", 32'(b_rise_cnt), 32'd0);
        chk("clr_keeps_rose", 32'(a_rose), 32'd1);

        // Run length, change, then reset mid-run.
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0);
        smp(8'h11, 1'b0);
        for (int i = 0; i < 4; i++) smp(8'h11, 1'b0);
        chk("run_len_4", 32'(a_run_len), 32'(exp_run(4, 255)));
        smp(8'h22, 1'b0);
        chk("run_len_change", 32'(a_run_len), 32'd0);
        smp(8'h22, 1'b0);
        smp(8'h22, 1'b1);
        cyc(1'b0, 1'b1, 8'h22, 1'b1, 3'd1, 1'b0);
        chk("midrst_run_len", 32'(a_run_len), 32'd0);
        chk("midrst_rise_cnt", 32'(a_rise_cnt), 32'd0);
        chk("midrst_past_data", 32'(a_past_data), 32'd0);
        smp(8'h22, 1'b0);
        chk("post_rst_vs_init", 32'(a_changed), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) < 7),
                8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
